dmem_arbiter: RTL and testbench

Two-master Wishbone-classic arbiter in front of the 8-bit, 256-entry data memory slave. It shares that single slave between master 0 (CPU load/store unit) and master 1 (loader/DMA port). It uses round-robin fairness with a cycle lock: a master keeps the grant for as long as it holds cyc. A stall watchdog terminates transactions the slave never acknowledges.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_watchdog.sv | 31 +++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
`timescale 1ns/1ps
package dmem_arb_pkg;

  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int TW          = $clog2(256);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  // Round-robin pick: on a tie the master not served most recently wins.
  function automatic arb_state_e arb_pick(input logic cyc0, input logic cyc1,
                                          input logic last_gnt);
    if (cyc0 && (!cyc1 || last_gnt)) return GNT0;
    if (cyc1) return GNT1;
    return IDLE;
  endfunction

endpackage

// File: rtl/dmem_arb_watchdog.sv
// Stall counter: counts consecutive unacknowledged strobe cycles of the granted master.
`timescale 1ns/1ps
module dmem_arb_watchdog
  import dmem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic stall_i,
  output logic expired_o
);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr_i || !stall_i) timer_d = '0;
    else                   timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timer_q <= '0;
    else         timer_q <= timer_d;
  end

  // Fires in the stalled cycle that would be the TIMEOUT-th in a row.
  assign expired_o = stall_i && (timer_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master Wishbone-classic arbiter with cycle lock, round-robin ties and stall abort.
`timescale 1ns/1ps
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       stall, expired, wd_clr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = arb_pick(m0_cyc_i, m1_cyc_i, last_gnt_q);
      GNT0: begin
        if (expired)        state_d = ABORT;
        else if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (expired)        state_d = ABORT;
        else if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      end
      // last_gnt still names the aborted master; wait for it to let go.
      ABORT: begin
        if (!(last_gnt_q ? m1_cyc_i : m0_cyc_i))
          state_d = arb_pick(m0_cyc_i, m1_cyc_i, last_gnt_q);
      end
      default: state_d = IDLE;
    endcase

    last_gnt_d = last_gnt_q;
    if (state_d == GNT0 && state_q != GNT0) last_gnt_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_gnt_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Slave-side mux; kept apart from the master side so the stall path has no loop.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    gnt_o   = 2'b00;
    case (state_q)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        gnt_o   = 2'b01;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        gnt_o   = 2'b10;
      end
      default: ;
    endcase
  end

  assign stall  = s_stb_o & ~s_ack_i;
  assign wd_clr = (state_d != state_q);

  dmem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (wd_clr),
    .stall_i   (stall),
    .expired_o (expired)
  );

  always_comb begin
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    case (state_q)
      GNT0: begin
        m0_ack_o = s_ack_i & ~expired;
        m0_err_o = expired;
        m0_dat_o = s_dat_i;
      end
      GNT1: begin
        m1_ack_o = s_ack_i & ~expired;
        m1_err_o = expired;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: slave stub, memory/round-robin reference model, directed and random rounds.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mcyc, mstb, mwe;
  logic [7:0] madr [2];
  logic [7:0] mdat [2];
  logic [1:0] mack, merr;
  logic [7:0] mdato [2];
  logic       s_cyc, s_stb, s_we, s_ack;
  logic [7:0] s_adr, s_dato, s_dati;
  logic [1:0] gnt;

  dmem_arbiter #(.AW(8), .DW(8), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_adr_i(madr[0]),
    .m0_dat_i(mdat[0]), .m0_dat_o(mdato[0]), .m0_ack_o(mack[0]), .m0_err_o(merr[0]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_adr_i(madr[1]),
    .m1_dat_i(mdat[1]), .m1_dat_o(mdato[1]), .m1_ack_o(mack[1]), .m1_err_o(merr[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dato),
    .s_dat_i(s_dati), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  // Slave stub: writes ack in the strobe cycle, reads one cycle later; noack stalls forever.
  logic [7:0] smem [256];
  logic       noack;
  logic       rd_pend_q;
  logic [7:0] rd_data_q;
  assign s_ack  = !noack && s_cyc && s_stb && (s_we || rd_pend_q);
  assign s_dati = rd_data_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_data_q <= 8'h00;
      for (int i = 0; i < 256; i++) smem[i] <= 8'h00;
    end else begin
      rd_pend_q <= s_cyc && s_stb && !s_we && !s_ack;
      rd_data_q <= smem[s_adr];
      if (s_cyc && s_stb && s_we && s_ack) smem[s_adr] <= s_dato;
    end
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model state
  logic [7:0] model_mem [256];
  int         last_served;
  int         errors = 0;
  int         checks = 0;

  int         n_acc [2];
  logic       acc_we  [2][4];
  logic [7:0] acc_adr [2][4];
  logic [7:0] acc_dat [2][4];
  logic [7:0] rd_res  [2][4];
  int         first_gnt [2];
  int         last_ack  [2];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    last_served = 1;
  endtask

  task automatic run_master(input int m);
    logic [1:0] mask;
    logic [1:0] mk;
    int  gs;
    bit  got;
    mask = (m == 0) ? 2'b01 : 2'b10;
    first_gnt[m] = -1;
    mcyc[m] = 1'b1;
    for (int i = 0; i < n_acc[m]; i++) begin
      mstb[m] = 1'b1; mwe[m] = acc_we[m][i]; madr[m] = acc_adr[m][i]; mdat[m] = acc_dat[m][i];
      gs = 0; got = 0;
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge clk);
        if (gnt == mask) begin
          gs++;
          if (first_gnt[m] < 0) first_gnt[m] = cyc_cnt;
          checks++;
          if (s_cyc !== 1'b1 || s_adr !== madr[m] || s_we !== mwe[m] ||
              (mwe[m] && s_dato !== mdat[m])) begin
            errors++;
            $display("FAIL mux m%0d: s_cyc=%b s_adr=%h s_we=%b s_dat=%h, required 1/%h/%b/%h",
                     m, s_cyc, s_adr, s_we, s_dato, madr[m], mwe[m], mdat[m]);
          end
        end
        for (int k = 0; k < 2; k++) begin
          mk = (k == 0) ? 2'b01 : 2'b10;
          if (gnt != mk) begin
            checks++;
            if (mack[k] !== 1'b0 || mdato[k] !== 8'h00) begin
              errors++;
              $display("FAIL isolation m%0d: ack=%b dat=%h with gnt=%b, required 0/00", k, mack[k], mdato[k], gnt);
            end
          end
        end
        checks++;
        if (merr[m] !== 1'b0 || (mack[m] === 1'b1 && gnt !== mask)) begin
          errors++;
          $display("FAIL err/ack m%0d: err=%b ack=%b gnt=%b, required err=0 and ack only when granted", m, merr[m], mack[m], gnt);
        end
        if (mack[m] === 1'b1) begin
          got = 1;
          rd_res[m][i] = mdato[m];
          last_ack[m] = cyc_cnt;
          checks++;
          if (gs != (acc_we[m][i] ? 1 : 2)) begin
            errors++;
            $display("FAIL ack_latency m%0d: %0d granted cycles, required %0d", m, gs, acc_we[m][i] ? 1 : 2);
          end
          $display("txn m%0d we=%b adr=%h wdat=%h rdat=%h cyc=%0d", m, acc_we[m][i], acc_adr[m][i],
                   acc_dat[m][i], mdato[m], cyc_cnt);
        end
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL ack_timeout m%0d: no ack, required ack within 200 cycles", m);
      end
      @(posedge clk); #1;
    end
    mstb[m] = 1'b0; mcyc[m] = 1'b0; mwe[m] = 1'b0;
  endtask

  // Round: selected masters raise cyc together; model decides order and read data.
  task automatic run_round(input bit u0, input bit u1);
    int start, win, lose, idx;
    win  = (u0 && (!u1 || last_served == 1)) ? 0 : 1;
    lose = 1 - win;
    @(posedge clk); #1;
    start = cyc_cnt;
    fork
      begin if (u0) run_master(0); end
      begin if (u1) run_master(1); end
    join
    checks++;
    if (first_gnt[win] != start + 1) begin
      errors++;
      $display("FAIL grant m%0d: first granted cycle %0d, required %0d", win, first_gnt[win], start + 1);
    end
    if (u0 && u1) begin
      checks++;
      if (first_gnt[lose] != last_ack[win] + 2) begin
        errors++;
        $display("FAIL handoff m%0d: granted at %0d, required %0d", lose, first_gnt[lose], last_ack[win] + 2);
      end
    end
    last_served = (u0 && u1) ? lose : win;
    for (int o = 0; o < ((u0 && u1) ? 2 : 1); o++) begin
      idx = (o == 0) ? win : lose;
      for (int i = 0; i < n_acc[idx]; i++) begin
        if (acc_we[idx][i]) model_mem[acc_adr[idx][i]] = acc_dat[idx][i];
        else begin
          checks++;
          if (rd_res[idx][i] !== model_mem[acc_adr[idx][i]]) begin
            errors++;
            $display("FAIL read_data m%0d adr=%h: got %h, required %h", idx, acc_adr[idx][i],
                     rd_res[idx][i], model_mem[acc_adr[idx][i]]);
          end
        end
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic set_acc(input int m, input int i, input logic we, input logic [7:0] adr,
                         input logic [7:0] dat);
    acc_we[m][i] = we; acc_adr[m][i] = adr; acc_dat[m][i] = dat;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    mcyc = 2'b11; mstb = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_cyc, s_stb, s_we, s_adr, s_dato, gnt, mack, merr, mdato[0], mdato[1]} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cyc=%b stb=%b gnt=%b ack=%b err=%b, required all 0", s_cyc, s_stb, gnt, mack, merr);
    end
    mcyc = 2'b00; mstb = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_m0();
    n_acc[0] = 1; set_acc(0, 0, 1'b1, 8'h10, 8'hA5);
    run_round(1'b1, 1'b0);
    set_acc(0, 0, 1'b0, 8'h10, 8'h00);
    run_round(1'b1, 1'b0);
  endtask

  task automatic test_tie();
    do_reset();
    n_acc[0] = 1; n_acc[1] = 1;
    set_acc(0, 0, 1'b1, 8'h20, 8'h5A);
    set_acc(1, 0, 1'b1, 8'h21, 8'hC3);
    run_round(1'b1, 1'b1);
    set_acc(0, 0, 1'b0, 8'h21, 8'h00);
    set_acc(1, 0, 1'b0, 8'h20, 8'h00);
    run_round(1'b1, 1'b1);
  endtask

  task automatic test_lock();
    n_acc[0] = 3; n_acc[1] = 1;
    set_acc(0, 0, 1'b1, 8'h01, 8'h11);
    set_acc(0, 1, 1'b1, 8'h02, 8'h22);
    set_acc(0, 2, 1'b1, 8'h03, 8'h33);
    set_acc(1, 0, 1'b0, 8'h02, 8'h00);
    run_round(1'b1, 1'b1);
  endtask

  task automatic test_timeout();
    int stalled, errc;
    bit got;
    noack = 1'b1;
    @(posedge clk); #1;
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b1; madr[0] = 8'h40; mdat[0] = 8'h77;
    @(posedge clk); #1;
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b0; madr[1] = 8'h02;
    stalled = 1; errc = -1;
    for (int w = 0; w < 100 && errc < 0; w++) begin
      @(negedge clk);
      if (merr[0] === 1'b1) errc = stalled;
      if (gnt == 2'b01) stalled++;
      checks++;
      if (mack !== 2'b00 || merr[1] !== 1'b0) begin
        errors++;
        $display("FAIL stall_ack: ack=%b err1=%b while stalled, required 00/0", mack, merr[1]);
      end
    end
    checks++;
    if (errc != TO) begin
      errors++;
      $display("FAIL timeout_cycle: err on stalled cycle %0d, required %0d", errc, TO);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0 || gnt !== 2'b00 || mack !== 2'b00 || merr !== 2'b00) begin
        errors++;
        $display("FAIL abort_hold: s_cyc=%b s_stb=%b gnt=%b ack=%b err=%b, required all 0", s_cyc, s_stb, gnt, mack, merr);
      end
    end
    @(posedge clk); #1;
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mwe[0] = 1'b0; noack = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00) begin
      errors++;
      $display("FAIL abort_exit: gnt=%b in release cycle, required 00", gnt);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10) begin
      errors++;
      $display("FAIL pending_m1: gnt=%b after abort, required 10", gnt);
    end
    got = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      if (mack[1] === 1'b1) begin
        got = 1;
        checks++;
        if (mdato[1] !== model_mem[8'h02]) begin
          errors++;
          $display("FAIL post_abort_read: got %h, required %h", mdato[1], model_mem[8'h02]);
        end
        $display("txn m1 we=0 adr=02 rdat=%h cyc=%0d (after abort)", mdato[1], cyc_cnt);
      end else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL post_abort_ack: no ack for m1, required ack");
    end
    @(posedge clk); #1;
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    last_served = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_async_reset();
    bit granted;
    @(posedge clk); #1;
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 8'h03;
    granted = 0;
    for (int w = 0; w < 10 && !granted; w++) begin
      @(negedge clk);
      if (gnt == 2'b01) granted = 1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || gnt !== 2'b00 || mack !== 2'b00 || mdato[0] !== 8'h00 || !granted) begin
      errors++;
      $display("FAIL async_reset: s_cyc=%b s_stb=%b gnt=%b ack=%b dat0=%h granted=%b, required 0/0/00/00/00/1",
               s_cyc, s_stb, gnt, mack, mdato[0], granted);
    end
    @(posedge clk); #1;
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    n_acc[0] = 1; n_acc[1] = 1;
    set_acc(0, 0, 1'b1, 8'h05, 8'h9C);
    set_acc(1, 0, 1'b0, 8'h05, 8'h00);
    run_round(1'b1, 1'b1);
  endtask

  task automatic test_random();
    int mode;
    for (int r = 0; r < 24; r++) begin
      mode = $urandom_range(0, 2);
      for (int m = 0; m < 2; m++) begin
        n_acc[m] = $urandom_range(1, 3);
        for (int i = 0; i < n_acc[m]; i++)
          set_acc(m, i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
      end
      run_round(mode != 1, mode != 0);
    end
  endtask

  initial begin
    mcyc = 2'b00; mstb = 2'b00; mwe = 2'b00; noack = 1'b0;
    madr[0] = 8'h00; madr[1] = 8'h00; mdat[0] = 8'h00; mdat[1] = 8'h00;
    model_reset();
    test_reset();
    test_single_m0();
    test_tie();
    test_lock();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
